// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic int idx_width(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage for the instruction memory: one synchronous write port and one
// registered read port whose output register clears on reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 8,
  parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register is cleared so the response word reads 0 straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: NOP clear sweep after reset, sequential program
// load, and a one-cycle-latency fetch port with alignment/range fault decode.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 8,
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_instr,
  output logic              resp_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              init_done
);

  localparam int               IDX_W    = idx_width(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             load_done_nxt;
  logic             clear_finish;

  logic             fetch_accept;
  logic             fetch_fault;
  logic [IDX_W-1:0] fetch_idx;

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [31:0]      wr_data;
  logic [31:0]      rd_data;

  // Any address bit above the indexed words, or a non-word offset, faults.
  assign fetch_idx    = fetch_addr[IDX_W+1:2];
  assign fetch_fault  = (fetch_addr[1:0] != 2'b00) ||
                        ((fetch_addr >> (IDX_W + 2)) != '0);
  assign fetch_accept = fetch_valid && fetch_ready;
  assign clear_finish = (state == CLEAR) && (cnt == LAST_IDX);

  // One counter serves as the clear sweep index and as the load pointer.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    load_done_nxt = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = cnt;
    wr_data       = NOP_INSTR;
    fetch_ready   = 1'b0;
    load_ready    = 1'b0;

    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end

      IDLE: begin
        fetch_ready = 1'b1;
        if (load_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end

      LOAD: begin
        load_ready = 1'b1;
        wr_data    = load_data;
        if (load_valid) begin
          wr_en   = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (load_last || (cnt == LAST_IDX)) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            load_done_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      init_done  <= 1'b0;
      load_done  <= 1'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      init_done  <= init_done || clear_finish;
      load_done  <= load_done_nxt;
      resp_valid <= fetch_accept;
      if (fetch_accept) begin
        resp_fault <= fetch_fault;
      end
    end
  end

  // The fault flag is registered alongside the read so the NOP substitution
  // lines up with the data coming out of the array one cycle later.
  assign resp_instr = resp_fault ? NOP_INSTR : rd_data;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && !rst),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (fetch_accept),
    .rd_addr (fetch_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed scenarios plus randomized
// loads/fetches checked against a word-array reference model.
module tb_imem_loadable;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        resp_fault;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_done;
  logic        init_done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model    [DEPTH];
  logic [31:0] load_buf [DEPTH];
  logic [31:0] prog     [DEPTH];

  always #5 clk = ~clk;

  imem_loadable #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (32),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .resp_valid  (resp_valid),
    .resp_instr  (resp_instr),
    .resp_fault  (resp_fault),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .init_done   (init_done)
  );

  // Reference: a fetch faults when not word aligned or beyond the last byte.
  function automatic logic exp_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    logic [31:0] r;
    if (exp_fault(a)) r = NOP;
    else              r = model[a / 4];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_fetch(input logic [31:0] a);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic run_load(input int n, input int last_pos, input bit do_start);
    if (do_start) begin
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = load_buf[i];
      load_last  = (i == last_pos);
      tick();
      model[i] = load_buf[i];
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (init_done !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b1;
    tick();
    tests_run++;
    if ({fetch_ready, resp_valid, resp_instr, resp_fault, load_ready, load_done, init_done} !== 38'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got fr=%b rv=%b ri=%h rf=%b lr=%b ld=%b id=%b expected all 0",
               fetch_ready, resp_valid, resp_instr, resp_fault, load_ready, load_done, init_done);
    end
    tick();
    rst = 1'b0;
    wait_init(c);
    tests_run++;
    if (c !== 8) begin
      tests_failed++;
      $display("[TB] FAIL clear_cycles: got %0d expected 8", c);
    end
    tests_run++;
    if (fetch_ready !== 1'b1 || load_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_ready: got fr=%b lr=%b expected fr=1 lr=0", fetch_ready, load_ready);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    issue_fetch(32'h10);
    tests_run++;
    if (resp_valid !== 1'b1 || resp_instr !== NOP || resp_fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_after_clear: got v=%b i=%h f=%b expected v=1 i=%h f=0",
               resp_valid, resp_instr, resp_fault, NOP);
    end
    tick();
    tests_run++;
    if (resp_valid !== 1'b0 || resp_instr !== NOP) begin
      tests_failed++;
      $display("[TB] FAIL resp_hold: got v=%b i=%h expected v=0 i=%h", resp_valid, resp_instr, NOP);
    end
  endtask

  task automatic test_load_full();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests_run++;
    if (load_ready !== 1'b1 || fetch_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_state_ready: got lr=%b fr=%b expected lr=1 fr=0", load_ready, fetch_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_start = (i == 4);
      tick();
      model[i] = prog[i];
      if (i < DEPTH - 1) begin
        tests_run++;
        if (load_done !== 1'b0 || load_ready !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL load_progress[%0d]: got ld=%b lr=%b expected ld=0 lr=1", i, load_done, load_ready);
        end
      end
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    tests_run++;
    if (load_done !== 1'b1 || fetch_ready !== 1'b1 || load_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_done_full: got ld=%b fr=%b lr=%b expected 1 1 0", load_done, fetch_ready, load_ready);
    end
    tick();
    tests_run++;
    if (load_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_done_pulse: got %b expected 0", load_done);
    end
    for (int i = 0; i < DEPTH; i++) begin
      issue_fetch(32'(i * 4));
      tests_run++;
      if (resp_valid !== 1'b1 || resp_instr !== exp_instr(32'(i * 4)) || resp_fault !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL loaded_word[%0d]: got v=%b i=%h f=%b expected v=1 i=%h f=0",
                 i, resp_valid, resp_instr, resp_fault, exp_instr(32'(i * 4)));
      end
    end
  endtask

  task automatic test_fetch_faults();
    logic [31:0] addrs [6];
    addrs[0] = 32'h06; addrs[1] = 32'h20; addrs[2] = 32'h1C;
    addrs[3] = 32'h01; addrs[4] = 32'h8000_0000; addrs[5] = 32'h23;
    for (int i = 0; i < 6; i++) begin
      issue_fetch(addrs[i]);
      tests_run++;
      if (resp_valid !== 1'b1 || resp_fault !== exp_fault(addrs[i]) || resp_instr !== exp_instr(addrs[i])) begin
        tests_failed++;
        $display("[TB] FAIL fault_decode[%h]: got v=%b f=%b i=%h expected v=1 f=%b i=%h",
                 addrs[i], resp_valid, resp_fault, resp_instr, exp_fault(addrs[i]), exp_instr(addrs[i]));
      end
    end
  endtask

  task automatic test_partial_reload();
    for (int i = 0; i < DEPTH; i++) load_buf[i] = $urandom();
    run_load(3, 2, 1'b1);
    tests_run++;
    if (load_done !== 1'b1 || fetch_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL partial_load_done: got ld=%b fr=%b expected 1 1", load_done, fetch_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      issue_fetch(32'(i * 4));
      tests_run++;
      if (resp_instr !== exp_instr(32'(i * 4))) begin
        tests_failed++;
        $display("[TB] FAIL partial_word[%0d]: got %h expected %h", i, resp_instr, exp_instr(32'(i * 4)));
      end
    end
    issue_fetch(32'h0C);
    tests_run++;
    if (resp_instr !== prog[3]) begin
      tests_failed++;
      $display("[TB] FAIL old_word3_kept: got %h expected %h", resp_instr, prog[3]);
    end
  endtask

  task automatic test_fetch_with_load_start();
    logic [31:0] old0;
    old0 = exp_instr(32'h0);
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0;
    load_start  = 1'b1;
    tick();
    fetch_valid = 1'b0;
    load_start  = 1'b0;
    tests_run++;
    if (resp_valid !== 1'b1 || resp_instr !== old0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_with_start_resp: got v=%b i=%h expected v=1 i=%h", resp_valid, resp_instr, old0);
    end
    tests_run++;
    if (fetch_ready !== 1'b0 || load_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fetch_with_start_state: got fr=%b lr=%b expected fr=0 lr=1", fetch_ready, load_ready);
    end
    load_buf[0] = 32'h00C5_8533;
    load_buf[1] = 32'h0000_8067;
    run_load(2, 1, 1'b0);
    tests_run++;
    if (load_done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fetch_with_start_load_done: got %b expected 1", load_done);
    end
    issue_fetch(32'h0);
    tests_run++;
    if (resp_instr !== 32'h00C5_8533) begin
      tests_failed++;
      $display("[TB] FAIL new_word0: got %h expected 00c58533", resp_instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] last_exp;
    last_exp = '0;
    fetch_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = (i % 3 == 2) ? $urandom() : 32'($urandom_range(0, DEPTH - 1) * 4);
      fetch_addr = a;
      tick();
      last_exp = exp_instr(a);
      tests_run++;
      if (resp_valid !== 1'b1 || resp_instr !== last_exp || resp_fault !== exp_fault(a)) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back[%0d] addr %h: got v=%b i=%h f=%b expected v=1 i=%h f=%b",
                 i, a, resp_valid, resp_instr, resp_fault, last_exp, exp_fault(a));
      end
    end
    fetch_valid = 1'b0;
    tick();
    tests_run++;
    if (resp_valid !== 1'b0 || resp_instr !== last_exp) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back_idle: got v=%b i=%h expected v=0 i=%h", resp_valid, resp_instr, last_exp);
    end
  endtask

  task automatic test_random();
    int          n;
    int          last_pos;
    logic [31:0] a;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, DEPTH);
        last_pos = (n == DEPTH && $urandom_range(0, 1) == 1) ? -1 : n - 1;
        for (int i = 0; i < DEPTH; i++) load_buf[i] = $urandom();
        run_load(n, last_pos, 1'b1);
        tests_run++;
        if (load_done !== 1'b1 || fetch_ready !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL rand_load[%0d] n=%0d: got ld=%b fr=%b expected 1 1", it, n, load_done, fetch_ready);
        end
      end else begin
        case ($urandom_range(0, 2))
          0:       a = 32'($urandom_range(0, DEPTH - 1) * 4);
          1:       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
          default: a = $urandom() | 32'h0000_0020;
        endcase
        issue_fetch(a);
        tests_run++;
        if (resp_valid !== 1'b1 || resp_instr !== exp_instr(a) || resp_fault !== exp_fault(a)) begin
          tests_failed++;
          $display("[TB] FAIL rand_fetch[%0d] addr %h: got v=%b i=%h f=%b expected v=1 i=%h f=%b",
                   it, a, resp_valid, resp_instr, resp_fault, exp_instr(a), exp_fault(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int c;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom();
      tick();
    end
    load_data = 32'hDEAD_BEEF;
    rst = 1'b1;
    tick();
    tests_run++;
    if ({fetch_ready, resp_valid, resp_instr, resp_fault, load_ready, load_done, init_done} !== 38'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_load: got fr=%b rv=%b ri=%h rf=%b lr=%b ld=%b id=%b expected all 0",
               fetch_ready, resp_valid, resp_instr, resp_fault, load_ready, load_done, init_done);
    end
    rst = 1'b0;
    load_valid = 1'b0;
    load_start = 1'b1;
    wait_init(c);
    load_start = 1'b0;
    tests_run++;
    if (c !== 8) begin
      tests_failed++;
      $display("[TB] FAIL reclear_cycles: got %0d expected 8", c);
    end
    tests_run++;
    if (fetch_ready !== 1'b1 || load_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL start_ignored_in_clear: got fr=%b lr=%b expected fr=1 lr=0", fetch_ready, load_ready);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    issue_fetch(32'h0);
    tests_run++;
    if (resp_instr !== NOP || resp_fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reclear_word0: got i=%h f=%b expected i=%h f=0", resp_instr, resp_fault, NOP);
    end
    issue_fetch(32'h0C);
    tests_run++;
    if (resp_instr !== NOP) begin
      tests_failed++;
      $display("[TB] FAIL reclear_word3: got %h expected %h", resp_instr, NOP);
    end
  endtask

  initial begin
    prog[0] = 32'h0020_8533; prog[1] = 32'h4031_0FB3;
    prog[2] = 32'h0020_A023; prog[3] = 32'h0000_A183;
    prog[4] = 32'h0041_8233; prog[5] = 32'hFE00_0EE3;
    prog[6] = 32'h0010_0093; prog[7] = 32'h0000_8067;
    test_reset();
    test_load_full();
    test_fetch_faults();
    test_partial_reload();
    test_fetch_with_load_start();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, loadable instruction memory for the RISC-V core: a word-organised store with a registered valid/ready fetch port, a sequential program-load port, and a self-clearing reset sweep that fills every word with a NOP. It sits between the PC/fetch stage and the instruction decoder. It replaces the fixed 32-byte, reset-populated memory with one that has a configurable depth, alignment and range faults, and runtime program loading.

## Interface
- DEPTH_WORDS, 8 — number of 32-bit words; must be a power of two, ≥2.
- ADDR_W, 32 — fetch address width in bytes.
- NOP_INSTR, 32'h0000_0013 — fill value (addi x0,x0,0).
- clk  in  1  — single clock; all state changes on its rising edge.
- rst  in  1  — synchronous, active-high reset.
- fetch_valid  in  1  — fetch request.
- fetch_addr  in  ADDR_W  — byte address of the instruction.
- fetch_ready  out  1  — fetch can be accepted this cycle.
- resp_valid  out  1  — response strobe, one cycle.
- resp_instr  out  32  — fetched instruction word.
- resp_fault  out  1  — misaligned or out-of-range fetch.
- load_start  in  1  — begin program load at word 0.
- load_valid  in  1  — load_data is valid.
- load_data  in  32  — instruction word, already little-endian assembled.
- load_last  in  1  — qualifies the final word of the load.
- load_ready  out  1  — load word can be accepted.
- load_done  out  1  — one-cycle pulse when the load completes.
- init_done  out  1  — high once the clear sweep has finished.

## Operation
- States: CLEAR, IDLE, LOAD.
- CLEAR
  - Entered on rst. The word counter starts at 0; writes NOP_INSTR to word[cnt] each cycle.
  - After writing word DEPTH_WORDS-1, moves to IDLE and sets init_done=1 (it stays 1 until the next rst).
  - fetch_ready=0 and load_ready=0 throughout. load_start is ignored.
- IDLE
  - fetch_ready=1, load_ready=0.
  - A fetch is accepted on fetch_valid&fetch_ready.
  - load_start moves the block to LOAD with load pointer=0.
- LOAD
  - fetch_ready=0, load_ready=1.
  - Each load_valid&load_ready writes load_data to word[ptr] and increments ptr.
  - Writing with load_last=1, or writing word DEPTH_WORDS-1, returns the block to IDLE with load_done=1 for one cycle.
  - Words not written keep their previous contents.
  - load_start while in LOAD is ignored.
- Fetch decode
  - idx = fetch_addr[IDX_W+1:2], where IDX_W = clog2(DEPTH_WORDS).
  - Fault if fetch_addr[1:0]≠0, or if any bit of fetch_addr above bit IDX_W+1 is set.
  - On fault: resp_instr=NOP_INSTR, resp_fault=1. Otherwise resp_instr=word[idx], resp_fault=0.
- fetch_valid and load_start in the same IDLE cycle: the fetch is accepted and answered from the pre-load contents, and the state moves to LOAD.
- There is no response backpressure; the consumer must take resp_* in the cycle resp_valid is high.

## Timing
- Reset values (the cycle after rst is sampled high): fetch_ready=0, resp_valid=0, resp_instr=0, resp_fault=0, load_ready=0, load_done=0, init_done=0, state=CLEAR.
- rst overrides every state, including mid-LOAD and mid-CLEAR. A partially loaded program is discarded by the new sweep.
- CLEAR lasts exactly DEPTH_WORDS cycles after rst deasserts; init_done and fetch_ready rise on the following edge.
- Fetch latency is 1 cycle: accept at edge N gives resp_valid at edge N+1. Back-to-back fetches give one response per cycle.
- resp_valid is 0 in any cycle after no accepted fetch; resp_instr/resp_fault hold their last values.
- Load throughput is one word per cycle. load_done is asserted in the cycle after the final write. fetch_ready returns in that same cycle.
- The read is synchronous from the array. A fetch never coincides with a load write, because fetch_ready=0 in LOAD.

## Structure
- Shared package imem_pkg holds:
  - state enum {CLEAR, IDLE, LOAD};
  - NOP_INSTR default constant;
  - an IDX_W helper function (clog2).
- Sub-module imem_array holds DEPTH_WORDS×32 storage with one synchronous write port (muxed between clear and load) and one synchronous read port.
- The top level holds the FSM, the counter/pointer, fault decode, and the response registers.

## Test plan
- Hold rst 2 cycles then release, DEPTH_WORDS=8 → init_done=1 after exactly 8 cycles; fetch 0x10 → resp_instr=0x00000013, resp_fault=0, one cycle later.
- load_start, then 8 words 0x00208533, 0x40310FB3, … with no load_last → load_done pulse after the 8th word; fetch 0x00 → 0x00208533, fetch 0x04 → 0x40310FB3.
- Fetch 0x06 → resp_fault=1, resp_instr=0x00000013; fetch 0x20 → resp_fault=1; fetch 0x1C → resp_fault=0.
- After a full load, reload 3 words with load_last on the 3rd → load_done after word 2; words 3–7 keep their old values; fetch 0x0C returns the old word 3.
- fetch_valid (addr 0x00) together with load_start in IDLE → the response carries the old word 0; the next cycle has fetch_ready=0 and load_ready=1.
- Assert rst after the 4th load word → all outputs 0 on the next edge; CLEAR re-runs; afterwards fetch 0x00 → 0x00000013.
